single_port_ram_controller: RTL
===============================

// Module: single_port_ram_controller
// PURPOSE
//   Front end for single_port_ram. Accepts independent valid/ready write and read-request
//   channels and arbitrates them onto the single RAM port, at most one access per cycle.
//   Absorbs the RAM's 1-cycle read latency and returns read data on a valid/ready response
//   channel. A 2-entry response buffer guarantees no data loss under back-pressure.
// PARAMETERS
//   WIDTH          8             data width in bits, matches the RAM WIDTH
//   DEPTH          16            number of RAM words, matches the RAM DEPTH
//   ADDRESS_WIDTH  CLOG2(DEPTH)  address width in bits
// PORTS
//   clock                  in   1              single clock, rising edge
//   reset                  in   1              asynchronous, active-high reset
//   write_valid            in   1              write request present
//   write_ready            out  1              write request accepted this cycle (when valid)
//   write_address          in   ADDRESS_WIDTH  write address
//   write_data             in   WIDTH          write data
//   read_request_valid     in   1              read request present
//   read_request_ready     out  1              read request accepted this cycle (when valid)
//   read_request_address   in   ADDRESS_WIDTH  read address
//   read_response_valid    out  1              read data available
//   read_response_ready    in   1              consumer takes read data
//   read_response_data     out  WIDTH          read data, in request order
//   ram_write_enable       out  1              to RAM write_enable
//   ram_read_enable        out  1              to RAM read_enable
//   ram_address            out  ADDRESS_WIDTH  to RAM address
//   ram_write_data         out  WIDTH          to RAM write_data
//   ram_read_data          in   WIDTH          from RAM read_data, valid 1 cycle after ram_read_enable
// BEHAVIOUR
//   State: in_flight (1b), response buffer (2 x WIDTH FIFO, count 0..2), priority (1b).
//   Reset (async, active-high): in_flight=0, count=0, priority=READ.
//     While reset is high: write_ready=0, read_request_ready=0, read_response_valid=0,
//     ram_write_enable=0, ram_read_enable=0. RAM contents are not touched.
//   Read credit: read_can = (count + in_flight) < 2. Computed from registered state only.
//   Arbitration, per cycle:
//     - Only write_valid:                        grant write.
//     - Only read_request_valid and read_can:    grant read.
//     - Both eligible: grant according to priority, then toggle priority.
//       Priority toggles only on a conflict cycle.
//     - write_ready          = !reset & !(read_request_valid & read_can & priority==READ).
//     - read_request_ready   = !reset & read_can & !(write_valid & priority==WRITE).
//   RAM drive (combinational):
//     - ram_write_enable = write_valid & write_ready.
//     - ram_read_enable  = read_request_valid & read_request_ready.
//     - ram_address      = read address on a read grant, else write_address.
//     - ram_write_data   = write_data.
//     - Write and read enables are never both 1.
//   Response path:
//     - in_flight <= ram_read_enable.
//     - read_response_valid = (count>0) | in_flight.
//     - read_response_data  = count>0 ? buffer head : ram_read_data (bypass only when buffer empty).
//     - If in_flight and the data is not consumed via bypass, push ram_read_data into the buffer.
//     - Pop the buffer head on a valid & ready handshake when count>0.
//     - A simultaneous push and pop keeps count unchanged.
//     - Order is strictly FIFO.
//   Latency:
//     - Read accepted in cycle N -> read_response_valid in cycle N+1 (zero-bubble bypass).
//     - Full throughput of 1 read/cycle when read_response_ready=1.
//   Hazards:
//     - Accesses are serialised in grant order.
//     - A read granted after a write to the same address returns the new data.
//   Back-pressure: at most 2 reads outstanding (in flight + buffered). Buffer overflow is impossible by credit.
//   Reset mid-operation: in-flight and buffered data are discarded; no stale response after reset release.
// TESTING
//   1. Write 0xA5 @3, then read @3, response_ready=1 -> response_valid the cycle after acceptance, data=0xA5.
//   2. Reads @0..15 back-to-back, RAM preloaded with mem[i]=i, ready=1 -> 16 accepts in 16 cycles,
//      responses 0..15 in order, no bubbles.
//   3. response_ready=0, read stream -> exactly 2 accepted, then read_request_ready=0;
//      raise ready -> both data in order, accepts resume.
//   4. write_valid and read_request_valid both held high after reset -> grants R,W,R,W...; never both RAM enables.
//   5. Write 0x3C @7 in cycle N, read @7 in cycle N+1 -> response 0x3C.
//   6. Assert reset with count=2 -> response_valid drops immediately, readies 0;
//      after release response_valid stays 0 until a new read.

Source files
------------

// File: rtl/single_port_ram_controller.sv
// ---------------------------------------------------------------------------
// single_port_ram_controller
//
// Front end for a single-port synchronous RAM. Two independent request
// channels (write, read-request) share the one RAM port, and at most one
// access is issued per cycle. The RAM's one-cycle read latency is absorbed
// here, and read data comes back on a valid/ready response channel in
// request order. A two-entry response buffer plus a read credit keeps data
// safe when the consumer stalls.
//
// Ports
//   clock_i                 rising-edge clock
//   reset_i                 asynchronous active-high reset
//   write_valid_i/_ready_o  write request handshake
//   write_address_i         write address
//   write_data_i            write data
//   read_request_valid_i    read request present
//   read_request_ready_o    read request accepted this cycle
//   read_request_address_i  read address
//   read_response_valid_o   read data available
//   read_response_ready_i   consumer takes read data
//   read_response_data_o    read data, in request order
//   ram_write_enable_o      RAM write strobe
//   ram_read_enable_o       RAM read strobe
//   ram_address_o           RAM address
//   ram_write_data_o        RAM write data
//   ram_read_data_i         RAM read data, valid one cycle after the read strobe
// ---------------------------------------------------------------------------
module single_port_ram_controller #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     write_valid_i,
  output logic                     write_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] write_address_i,
  input  logic [WIDTH-1:0]         write_data_i,
  input  logic                     read_request_valid_i,
  output logic                     read_request_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] read_request_address_i,
  output logic                     read_response_valid_o,
  input  logic                     read_response_ready_i,
  output logic [WIDTH-1:0]         read_response_data_o,
  output logic                     ram_write_enable_o,
  output logic                     ram_read_enable_o,
  output logic [ADDRESS_WIDTH-1:0] ram_address_o,
  output logic [WIDTH-1:0]         ram_write_data_o,
  input  logic [WIDTH-1:0]         ram_read_data_i
);

  typedef enum logic {
    PRIO_READ  = 1'b0,
    PRIO_WRITE = 1'b1
  } priority_e;

  priority_e        prio_q, prio_d;
  logic             inFlight_q, inFlight_d;
  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic [WIDTH-1:0] buffer_q [2];

  logic readCan;
  logic conflict;
  logic bufNotEmpty;
  logic bypass;
  logic push;
  logic pop;
  logic tailIdx;

  // Read credit comes only from registered state, so a read is accepted
  // only when there is guaranteed room for its response.
  assign readCan     = (count_q + {1'b0, inFlight_q}) < 2'd2;
  assign bufNotEmpty = (count_q != 2'd0);

  // Arbitration: a lone requester always wins; on a conflict the
  // priority bit decides and then flips so both channels make progress.
  always_comb begin
    conflict             = 1'b0;
    prio_d               = prio_q;
    write_ready_o        = 1'b0;
    read_request_ready_o = 1'b0;
    if (!reset_i) begin
      write_ready_o        = !(read_request_valid_i && readCan && (prio_q == PRIO_READ));
      read_request_ready_o = readCan && !(write_valid_i && (prio_q == PRIO_WRITE));
      conflict             = write_valid_i && read_request_valid_i && readCan;
    end
    if (conflict) begin
      prio_d = (prio_q == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
    end
  end

  assign ram_write_enable_o = write_valid_i && write_ready_o;
  assign ram_read_enable_o  = read_request_valid_i && read_request_ready_o;
  assign ram_address_o      = ram_read_enable_o ? read_request_address_i : write_address_i;
  assign ram_write_data_o   = write_data_i;

  // Response path: RAM data is forwarded straight out when nothing older
  // is buffered; otherwise it is queued behind the buffered entries.
  assign read_response_valid_o = !reset_i && (bufNotEmpty || inFlight_q);
  assign read_response_data_o  = bufNotEmpty ? buffer_q[head_q] : ram_read_data_i;

  assign bypass  = inFlight_q && !bufNotEmpty && read_response_ready_i;
  assign push    = inFlight_q && !bypass;
  assign pop     = bufNotEmpty && read_response_ready_i;
  // Push only happens with count <= 1, so head + count wraps to head ^ count[0].
  assign tailIdx = head_q ^ count_q[0];

  always_comb begin
    inFlight_d = ram_read_enable_o;
    count_d    = count_q;
    head_d     = head_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      head_d = ~head_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      prio_q     <= PRIO_READ;
      inFlight_q <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      inFlight_q <= inFlight_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  // Buffer storage is pure data; validity lives in count_q, so no reset.
  always_ff @(posedge clock_i) begin
    if (push) begin
      buffer_q[tailIdx] <= ram_read_data_i;
    end
  end

endmodule
